// File: rtl/conv3x3_seq.sv
// Sequential 3x3 convolution: loads nine signed weights and nine unsigned pixels,
// accumulates one tap per cycle, then emits a shifted, ReLU'd and saturated byte.
module conv3x3_seq #(
  parameter int SHIFT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       mode,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       weights_ok
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_P,
    MAC,
    OUT
  } state_t;

  localparam logic [3:0] LAST_TAP = 4'd8;

  state_t            state;
  logic [3:0]        idx;
  logic signed [19:0] acc;
  logic [7:0]        w_mem [9];
  logic [7:0]        p_mem [9];

  logic              accept;
  logic [3:0]        tap;
  logic [7:0]        w_tap;
  logic [7:0]        p_tap;
  logic signed [16:0] w_ext;
  logic signed [16:0] p_ext;
  logic signed [16:0] prod;
  logic signed [19:0] shifted;
  logic [7:0]        sat;

  // A pixel frame is only offered once a full weight set exists.
  always_comb begin
    in_ready = 1'b0;
    if (ena) begin
      case (state)
        LOAD_W, LOAD_P: in_ready = 1'b1;
        IDLE:           in_ready = !mode || weights_ok;
        default:        in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid && in_ready;
  assign busy   = (state != IDLE);

  // idx runs one past the last tap to mark the result-load cycle; clamp the read index.
  assign tap   = (idx > LAST_TAP) ? 4'd0 : idx;
  assign w_tap = w_mem[tap];
  assign p_tap = p_mem[tap];
  assign w_ext = {{9{w_tap[7]}}, w_tap};
  assign p_ext = {9'd0, p_tap};
  assign prod  = w_ext * p_ext;

  assign shifted = acc >>> SHIFT;

  always_comb begin
    sat = 8'd0;
    if (shifted < 0)
      sat = 8'd0;
    else if (shifted > 20'sd255)
      sat = 8'd255;
    else
      sat = shifted[7:0];
  end

  // NOTE: the tap memories are small register arrays that must read as zero after
  // reset, so they are cleared here rather than left uninitialised like a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      acc        <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      weights_ok <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        w_mem[i] <= '0;
        p_mem[i] <= '0;
      end
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (accept) begin
            idx <= 4'd1;
            if (!mode) begin
              w_mem[0] <= in_data;
              state    <= LOAD_W;
            end else begin
              p_mem[0] <= in_data;
              state    <= LOAD_P;
            end
          end
        end

        LOAD_W: begin
          if (accept) begin
            w_mem[idx] <= in_data;
            if (idx == LAST_TAP) begin
              idx        <= '0;
              weights_ok <= 1'b1;
              state      <= IDLE;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end

        LOAD_P: begin
          if (accept) begin
            p_mem[idx] <= in_data;
            if (idx == LAST_TAP) begin
              idx   <= '0;
              acc   <= '0;
              state <= MAC;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end

        MAC: begin
          if (idx <= LAST_TAP) begin
            acc <= acc + {{3{prod[16]}}, prod};
            idx <= idx + 4'd1;
          end else begin
            out_data  <= sat;
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= OUT;
          end
        end

        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv3x3_seq.sv
// Directed-plus-random bench for conv3x3_seq; expected results come from a plain
// integer dot-product model of the frame contents.
module tb_conv3x3_seq;

  localparam int SHIFT = 4;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       mode;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       weights_ok;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_accept = 0;

  int wm [9];
  int pm [9];

  conv3x3_seq #(.SHIFT(SHIFT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .mode      (mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .weights_ok(weights_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after a rising edge, well clear of the next one.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic int model_result();
    int sum;
    int r;
    sum = 0;
    for (int i = 0; i < 9; i++) sum += wm[i] * pm[i];
    r = sum >>> SHIFT;
    if (r < 0) return 0;
    if (r > 255) return 255;
    return r;
  endfunction

  task automatic send_byte(input logic m, input int b, input bit gaps);
    int n;
    logic [31:0] bv;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end
    bv       = b;
    mode     = m;
    in_data  = bv[7:0];
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    step();
    in_valid    = 1'b0;
    last_accept = cyc;
  endtask

  task automatic load_weights(input bit gaps);
    for (int i = 0; i < 9; i++) send_byte(1'b0, wm[i], gaps);
  endtask

  task automatic send_pixels(input bit gaps);
    for (int i = 0; i < 9; i++) send_byte(1'b1, pm[i], gaps);
  endtask

  // Waits for a result after the last pixel; optional ena stall inside MAC.
  task automatic wait_result(input int stall, output int lat);
    int n;
    if (stall > 0) begin
      repeat (3) step();
      ena = 1'b0;
      repeat (stall) begin
        step();
        check("stall_in_ready", int'(in_ready), 0);
      end
      check("stall_busy", int'(busy), 1);
      ena = 1'b1;
    end
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    if (!out_valid) check("out_valid_timeout", 0, 1);
    lat = cyc - last_accept;
  endtask

  task automatic consume(input int exp_data);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("consume_busy", int'(busy), 0);
    check("consume_out_valid", int'(out_valid), 0);
    check("consume_data_held", int'(out_data), exp_data);
  endtask

  task automatic run_conv(input string tag, input bit gaps, input int stall, output int res, output int lat);
    int exp;
    exp = model_result();
    send_pixels(gaps);
    wait_result(stall, lat);
    check({tag, "_latency"}, lat, 10 + stall);
    check({tag, "_data"}, int'(out_data), exp);
    res = int'(out_data);
    consume(exp);
  endtask

  int res_a, lat_a, res_b, lat_b;
  int hold_data;

  initial begin
    rst_n = 1'b0; ena = 1'b1; mode = 1'b1; in_data = '0;
    in_valid = 1'b1; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_weights_ok", int'(weights_ok), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    in_valid = 1'b0;
    step();

    // Unity weights over flat 16s.
    for (int i = 0; i < 9; i++) begin wm[i] = 1; pm[i] = 16; end
    load_weights(1'b0);
    check("w1_weights_ok", int'(weights_ok), 1);
    check("w1_busy", int'(busy), 0);
    run_conv("ones", 1'b0, 0, res_a, lat_a);

    // Negative sum clamps to zero.
    for (int i = 0; i < 9; i++) begin wm[i] = -1; pm[i] = 100; end
    load_weights(1'b1);
    run_conv("relu", 1'b0, 0, res_a, lat_a);

    // Large positive sum clamps to 255.
    for (int i = 0; i < 9; i++) begin wm[i] = 127; pm[i] = 255; end
    load_weights(1'b0);
    run_conv("sat", 1'b1, 0, res_a, lat_a);

    // Partial weight frame leaves weights_ok set until it completes.
    for (int i = 0; i < 9; i++) wm[i] = int'($urandom_range(0, 6)) - 3;
    for (int i = 0; i < 4; i++) send_byte(1'b0, wm[i], 1'b1);
    check("partial_weights_ok", int'(weights_ok), 1);
    check("partial_busy", int'(busy), 1);
    mode = 1'b1;
    #1;
    check("partial_in_ready", int'(in_ready), 1);
    for (int i = 4; i < 9; i++) send_byte(1'b0, wm[i], 1'b1);
    check("partial_done_busy", int'(busy), 0);

    // Pending result holds while out_ready stays low.
    for (int i = 0; i < 9; i++) pm[i] = int'($urandom_range(0, 255));
    send_pixels(1'b1);
    wait_result(0, lat_a);
    check("hold_data0", int'(out_data), model_result());
    hold_data = int'(out_data);
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      mode     = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      step();
      check("hold_out_valid", int'(out_valid), 1);
      check("hold_out_data", int'(out_data), hold_data);
      check("hold_in_ready", int'(in_ready), 0);
      check("hold_busy", int'(busy), 1);
    end
    in_valid = 1'b0;
    consume(hold_data);

    // Random frames, some with fresh weights, some with gaps or an ena stall.
    for (int f = 0; f < 6; f++) begin
      if (f % 2 == 0) begin
        for (int i = 0; i < 9; i++) wm[i] = int'($urandom_range(0, 10)) - 5;
        load_weights(f > 2);
      end
      for (int i = 0; i < 9; i++) pm[i] = int'($urandom_range(0, 255));
      run_conv("rand", 1'(f % 2), (f == 3) ? 2 : 0, res_a, lat_a);
    end

    // Same frame, clean versus gapped with a 3-cycle ena stall mid-MAC.
    for (int i = 0; i < 9; i++) pm[i] = int'($urandom_range(0, 255));
    run_conv("clean", 1'b0, 0, res_a, lat_a);
    run_conv("stalled", 1'b1, 3, res_b, lat_b);
    check("stall_same_result", res_b, res_a);
    check("stall_extra_latency", lat_b - lat_a, 3);

    // Reset during the fifth MAC cycle.
    for (int i = 0; i < 9; i++) pm[i] = int'($urandom_range(0, 255));
    send_pixels(1'b0);
    repeat (4) step();
    check("mac_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", int'(busy), 0);
    check("mrst_weights_ok", int'(weights_ok), 0);
    check("mrst_out_valid", int'(out_valid), 0);
    check("mrst_out_data", int'(out_data), 0);
    step();
    rst_n    = 1'b1;
    mode     = 1'b1;
    in_data  = 8'd7;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("mrst_refuse_in_ready", int'(in_ready), 0);
      step();
      check("mrst_refuse_busy", int'(busy), 0);
    end
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
